mem_copy_engine: RTL and testbench

Block-copy initiator for the 256×8 data memory: on a start strobe it reads `length` bytes from consecutive source addresses and writes them to consecutive destination addresses. It drives the memory's write-enable, write-address, write-data and read-address inputs and consumes its combinational read-data output. It sits between the control unit and the data memory. It runs in parallel with the normal memory ports through an external arbiter, which grants the memory to the engine while `busy` is high.

---
 rtl/mem_copy_engine.sv | 187 ++++++++++++++++++
 tb/tb_mem_copy_engine.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
// ---------------------------------------------------------------------------
// Block-copy initiator for the 256x8 data memory. A start request latches the
// source/destination pointers and a byte count. The engine then streams bytes
// from ascending source addresses to ascending destination addresses at one
// byte per cycle after a single fill (FETCH) cycle.
//
// Optional feature: define MEMCPY_CHECKSUM_EN to build a modulo-256 sum of
// every written byte. Without it, checksum is tied to zero.
//
// Ports
//   clock            system clock, rising edge
//   reset            synchronous, active-high
//   start            copy request, sampled only in IDLE
//   src_addr         first source address (latched on accepted start)
//   dst_addr         first destination address (latched on accepted start)
//   length           byte count (latched on accepted start); 0 = no transfer
//   busy             high in FETCH, STREAM and LAST
//   done             one-cycle completion pulse
//   mem_read_addr    memory read address (source pointer)
//   mem_read_data    memory combinational read data
//   mem_write_enable memory write enable
//   mem_write_addr   memory write address (destination pointer)
//   mem_write_data   memory write data (staging register)
//   checksum         modulo-256 sum of written bytes (0 if feature disabled)
//   o_dbg_state      current FSM state encoding, for observation only
//
// Handshake: start is a level-sensitive request with no ready signal. It is
// accepted only in a cycle where the FSM is IDLE; a start seen in any other
// state is dropped, not queued. Completion is signalled by the done pulse.
// ---------------------------------------------------------------------------
module mem_copy_engine (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] length,
    output logic       busy,
    output logic       done,
    output logic [7:0] mem_read_addr,
    input  logic [7:0] mem_read_data,
    output logic       mem_write_enable,
    output logic [7:0] mem_write_addr,
    output logic [7:0] mem_write_data,
    output logic [7:0] checksum,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_STREAM = 3'd2,
        S_LAST   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_src;
    logic [7:0] r_dst;
    logic [7:0] r_cnt;
    logic [7:0] r_stage;
    logic       w_busy;
    logic       w_done;
    logic       w_we;
    logic       w_accept;
    logic [7:0] w_cnt_dec;

    assign w_cnt_dec = r_cnt - 8'd1;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode; outputs depend only on r_state so they
    // are glitch-free with respect to the clock.
    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_we     = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (length != 8'd0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                w_busy = 1'b1;
                w_next = (w_cnt_dec != 8'd0) ? S_STREAM : S_LAST;
            end
            S_STREAM: begin
                w_busy = 1'b1;
                w_we   = 1'b1;
                w_next = (w_cnt_dec != 8'd0) ? S_STREAM : S_LAST;
            end
            S_LAST: begin
                w_busy = 1'b1;
                w_we   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: pointers, read counter, staging register.
    // r_cnt counts bytes still to be read, so it reaches zero one cycle
    // before the last write (the LAST state drains the staging register).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_src   <= 8'd0;
            r_dst   <= 8'd0;
            r_cnt   <= 8'd0;
            r_stage <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (length != 8'd0)) begin
                        r_src <= src_addr;
                        r_dst <= dst_addr;
                        r_cnt <= length;
                    end
                end
                S_FETCH: begin
                    r_stage <= mem_read_data;
                    r_src   <= r_src + 8'd1;
                    r_cnt   <= w_cnt_dec;
                end
                S_STREAM: begin
                    // The write of r_stage and the read of the next byte share
                    // this cycle, so a read sees memory as committed before it.
                    r_stage <= mem_read_data;
                    r_src   <= r_src + 8'd1;
                    r_dst   <= r_dst + 8'd1;
                    r_cnt   <= w_cnt_dec;
                end
                S_LAST: begin
                    r_dst <= r_dst + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEMCPY_CHECKSUM_EN
    logic [7:0] r_csum;

    // Cleared on any accepted start (including length 0); holds after done.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_csum <= 8'd0;
        end else if (w_accept) begin
            r_csum <= 8'd0;
        end else if (w_we) begin
            r_csum <= r_csum + r_stage;
        end
    end

    assign checksum = r_csum;
`else
    assign checksum = 8'h00;
`endif

    assign busy             = w_busy;
    assign done             = w_done;
    assign mem_write_enable = w_we;
    assign mem_read_addr    = r_src;
    assign mem_write_addr   = r_dst;
    assign mem_write_data   = r_stage;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed testbench for mem_copy_engine with a behavioural 256x8 memory
// (combinational read, write committed at the rising edge).
// Cycle numbering: the start request is sampled at edge E0; cycle k is the
// interval after edge E(k-1). Outputs are sampled 1 time unit after an edge.
module tb_mem_copy_engine;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] length;
    logic       busy;
    logic       done;
    logic [7:0] mem_read_addr;
    logic [7:0] mem_read_data;
    logic       mem_write_enable;
    logic [7:0] mem_write_addr;
    logic [7:0] mem_write_data;
    logic [7:0] checksum;
    logic [2:0] o_dbg_state;

    int n_vec;
    int n_err;

    logic [15:0] exp_q[$];

    // ------------------------------------------------------------ clock/reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ------------------------------------------------------------ memory model
    logic [7:0] mem [0:255];
    logic       pl_we;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge clock) begin
        if (mem_write_enable) begin
            mem[mem_write_addr] <= mem_write_data;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end
    end

    assign mem_read_data = mem[mem_read_addr];

    mem_copy_engine dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .src_addr         (src_addr),
        .dst_addr         (dst_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .mem_read_addr    (mem_read_addr),
        .mem_read_data    (mem_read_data),
        .mem_write_enable (mem_write_enable),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data),
        .checksum         (checksum),
        .o_dbg_state      (o_dbg_state)
    );

    // ------------------------------------------------------------ drivers
    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clock); #1;
        pl_we   = 1'b0;
    endtask

    // Holds start for one edge; returns in cycle 1.
    task automatic kick(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        src_addr = s;
        dst_addr = d;
        length   = l;
        start    = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
    endtask

    function automatic logic [7:0] exp_ck(input logic [7:0] sum);
`ifdef MEMCPY_CHECKSUM_EN
        return sum;
`else
        return 8'h00 & sum;
`endif
    endfunction

    // ------------------------------------------------------------ tests
    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_vec++;
        if ({busy, done, mem_write_enable} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want 000", {busy, done, mem_write_enable});
        end
        n_vec++;
        if ({mem_read_addr, mem_write_addr, mem_write_data, checksum} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data got %h want 00000000",
                     {mem_read_addr, mem_write_addr, mem_write_data, checksum});
        end
        n_vec++;
        if (o_dbg_state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state got %0d want 0", o_dbg_state);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_basic;
        logic [7:0]  b [4];
        logic [7:0]  sum;
        logic [15:0] e;
        b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        sum = 8'h00;
        for (int i = 0; i < 4; i++) begin
            preload(8'h10 + 8'(i), b[i]);
            preload(8'h80 + 8'(i), 8'h00);
            sum = sum + b[i];
        end
        preload(8'h84, 8'h5A);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({8'h80 + 8'(i), b[i]});
        kick(8'h10, 8'h80, 8'd4);
        for (int c = 1; c <= 6; c++) begin
            n_vec++;
            if (busy !== (c <= 5)) begin
                n_err++;
                $display("FAIL basic_busy c=%0d got %b want %b", c, busy, (c <= 5));
            end
            n_vec++;
            if (mem_write_enable !== (c >= 2 && c <= 5)) begin
                n_err++;
                $display("FAIL basic_we c=%0d got %b want %b", c, mem_write_enable, (c >= 2 && c <= 5));
            end
            n_vec++;
            if (done !== (c == 6)) begin
                n_err++;
                $display("FAIL basic_done c=%0d got %b want %b", c, done, (c == 6));
            end
            if (c == 1) begin
                n_vec++;
                if (mem_read_addr !== 8'h10) begin
                    n_err++;
                    $display("FAIL basic_raddr got %h want 10", mem_read_addr);
                end
            end
            if (mem_write_enable === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL basic_extra_write c=%0d got %h:%h want none", c, mem_write_addr, mem_write_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_write_addr, mem_write_data} !== e) begin
                        n_err++;
                        $display("FAIL basic_write c=%0d got %h:%h want %h:%h",
                                 c, mem_write_addr, mem_write_data, e[15:8], e[7:0]);
                    end
                end
            end
            @(posedge clock); #1;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL basic_missing_writes got %0d left want 0", exp_q.size());
        end
        n_vec++;
        if (checksum !== exp_ck(sum)) begin
            n_err++;
            $display("FAIL basic_checksum got %h want %h", checksum, exp_ck(sum));
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (mem[8'h80 + 8'(i)] !== b[i]) begin
                n_err++;
                $display("FAIL basic_mem[%0d] got %h want %h", i, mem[8'h80 + 8'(i)], b[i]);
            end
        end
        n_vec++;
        if (mem[8'h84] !== 8'h5A) begin
            n_err++;
            $display("FAIL basic_overrun got %h want 5a", mem[8'h84]);
        end
    endtask

    task automatic test_zero_len;
        kick(8'h40, 8'h90, 8'd0);
        for (int c = 1; c <= 3; c++) begin
            n_vec++;
            if ({busy, mem_write_enable, done} !== {1'b0, 1'b0, (c == 1)}) begin
                n_err++;
                $display("FAIL zero_ctrl c=%0d got %b want 00%b", c, {busy, mem_write_enable, done}, (c == 1));
            end
            @(posedge clock); #1;
        end
        n_vec++;
        if (checksum !== 8'h00) begin
            n_err++;
            $display("FAIL zero_checksum got %h want 00", checksum);
        end
    endtask

    task automatic test_wrap;
        // dst-src = 3 (mod 256) lies in [2, length-1], so the byte at 0x01
        // is overwritten (with 11) before it is read: final 11,22,33,11.
        logic [7:0] want [4];
        want = '{8'h11, 8'h22, 8'h33, 8'h11};
        preload(8'hFE, 8'h11);
        preload(8'hFF, 8'h22);
        preload(8'h00, 8'h33);
        preload(8'h01, 8'h44);
        for (int i = 2; i <= 4; i++) preload(8'(i), 8'h00);
        kick(8'hFE, 8'h01, 8'd4);
        for (int c = 1; c <= 6; c++) begin
            if (c == 3) begin
                n_vec++;
                if (mem_read_addr !== 8'h00) begin
                    n_err++;
                    $display("FAIL wrap_raddr got %h want 00", mem_read_addr);
                end
            end
            @(posedge clock); #1;
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (mem[8'(i + 1)] !== want[i]) begin
                n_err++;
                $display("FAIL wrap_mem[%0d] got %h want %h", i + 1, mem[8'(i + 1)], want[i]);
            end
        end
        n_vec++;
        if (checksum !== exp_ck(8'h77)) begin
            n_err++;
            $display("FAIL wrap_checksum got %h want %h", checksum, exp_ck(8'h77));
        end
    endtask

    task automatic test_overlap;
        logic [7:0] want [4];
        want = '{8'd1, 8'd2, 8'd1, 8'd2};
        for (int i = 0; i < 4; i++) preload(8'h20 + 8'(i), 8'(i + 1));
        preload(8'h24, 8'h00);
        preload(8'h25, 8'h00);
        kick(8'h20, 8'h22, 8'd4);
        repeat (6) begin
            @(posedge clock); #1;
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (mem[8'h22 + 8'(i)] !== want[i]) begin
                n_err++;
                $display("FAIL overlap_mem[%0d] got %h want %h", i, mem[8'h22 + 8'(i)], want[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        for (int i = 0; i < 3; i++) begin
            preload(8'h30 + 8'(i), 8'h05 + 8'(i));
            preload(8'hA0 + 8'(i), 8'h00);
        end
        preload(8'hC0, 8'hEE);
        kick(8'h30, 8'hA0, 8'd3);
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) begin
                src_addr = 8'h50;
                dst_addr = 8'hC0;
                length   = 8'd5;
                start    = 1'b1;
            end
            if (c == 4) start = 1'b0;
            if (c == 3) begin
                n_vec++;
                if (mem_write_addr !== 8'hA1) begin
                    n_err++;
                    $display("FAIL ignore_waddr got %h want a1", mem_write_addr);
                end
            end
            n_vec++;
            if (done !== (c == 5)) begin
                n_err++;
                $display("FAIL ignore_done c=%0d got %b want %b", c, done, (c == 5));
            end
            @(posedge clock); #1;
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (mem[8'hA0 + 8'(i)] !== 8'h05 + 8'(i)) begin
                n_err++;
                $display("FAIL ignore_mem[%0d] got %h want %h", i, mem[8'hA0 + 8'(i)], 8'h05 + 8'(i));
            end
        end
        n_vec++;
        if (mem[8'hC0] !== 8'hEE) begin
            n_err++;
            $display("FAIL ignore_second_copy got %h want ee", mem[8'hC0]);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 8; i++) begin
            preload(8'h60 + 8'(i), 8'h71 + 8'(i));
            preload(8'hB0 + 8'(i), 8'h00);
        end
        kick(8'h60, 8'hB0, 8'd8);
        @(posedge clock); #1;
        // Now in cycle 2 (first write); reset sampled at the end of it.
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_vec++;
        if ({busy, done, mem_write_enable, o_dbg_state} !== 6'b000000) begin
            n_err++;
            $display("FAIL rstmid_ctrl got %b want 000000", {busy, done, mem_write_enable, o_dbg_state});
        end
        n_vec++;
        if ({mem_read_addr, mem_write_addr, mem_write_data, checksum} !== 32'h0) begin
            n_err++;
            $display("FAIL rstmid_data got %h want 00000000",
                     {mem_read_addr, mem_write_addr, mem_write_data, checksum});
        end
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if ({busy, done} !== 2'b00) begin
                n_err++;
                $display("FAIL rstmid_idle c=%0d got %b want 00", c, {busy, done});
            end
            @(posedge clock); #1;
        end
        n_vec++;
        if (mem[8'hB0] !== 8'h71) begin
            n_err++;
            $display("FAIL rstmid_first got %h want 71", mem[8'hB0]);
        end
        n_vec++;
        if (mem[8'hB1] !== 8'h00) begin
            n_err++;
            $display("FAIL rstmid_second got %h want 00", mem[8'hB1]);
        end
    endtask

    task automatic test_back_to_back;
        preload(8'h10, 8'hA1);
        preload(8'h11, 8'hB2);
        preload(8'hD0, 8'h00);
        preload(8'hD1, 8'h00);
        kick(8'h10, 8'hD0, 8'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done1 got %b want 1", done);
        end
        @(posedge clock); #1;
        kick(8'h11, 8'hD1, 8'd1);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept got %b want 1", busy);
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done2 got %b want 1", done);
        end
        n_vec++;
        if ({mem[8'hD0], mem[8'hD1]} !== 16'hA1B2) begin
            n_err++;
            $display("FAIL b2b_mem got %h%h want a1b2", mem[8'hD0], mem[8'hD1]);
        end
        n_vec++;
        if (checksum !== exp_ck(8'hB2)) begin
            n_err++;
            $display("FAIL b2b_checksum got %h want %h", checksum, exp_ck(8'hB2));
        end
        @(posedge clock); #1;
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        length   = 8'h00;
        pl_we    = 1'b0;
        pl_addr  = 8'h00;
        pl_data  = 8'h00;
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_overlap();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
